cpuclk_edge_gen: RTL and testbench

Upstream stage of the bus core. Samples the asynchronous CPU clock on clk100 through a synchronizer and glitch filter, and produces the single-cycle cpuclk_rising/cpuclk_falling strobes the core's arbitration and access FSMs step on. Measures the CPU clock period and gates the strobes with a lock qualifier, so the core never runs on a missing or unstable clock.

---
 rtl/rebuster_pkg.sv | 9 +
 rtl/cpuclk_edge_gen_if.sv | 39 +++
 rtl/edge_sync_filter.sv | 37 +++
 rtl/cpuclk_edge_gen.sv | 97 +++++++++
 tb/tb_cpuclk_edge_gen.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/rebuster_pkg.sv
// rebuster_pkg: lock-state encoding and default tuning constants shared by the CPU clock edge path
package rebuster_pkg;
  typedef enum logic [1:0] {UNLOCKED, FIRST, ACQUIRE, LOCKED} lock_state_t;
  localparam int SYNC_STAGES_D = 2;
  localparam int FILTER_LEN_D = 2;
  localparam int PERIOD_W_D = 6;
  localparam int LOCK_COUNT_D = 8;
  localparam int PERIOD_TOL_D = 1;
endpackage

// File: rtl/cpuclk_edge_gen_if.sv
// cpuclk_edge_gen_if: CPU clock input, edge strobes and lock status toward the bus core
// CPUCLK_EDGE_C7M_EN adds the c7m_in edge path signals.
interface cpuclk_edge_gen_if
  import rebuster_pkg::*;
#(
  parameter int PERIOD_W = PERIOD_W_D
);
  logic cpuclk_in;
  logic cpuclk_rising;
  logic cpuclk_falling;
  logic cpuclk_locked;
  logic cpuclk_lost;
  logic [PERIOD_W-1:0] cpuclk_period;
`ifdef CPUCLK_EDGE_C7M_EN
  logic c7m_in;
  logic c7m_sync;
  logic c7m_rising;
  logic c7m_falling;
  modport slave (
    input cpuclk_in, c7m_in,
    output cpuclk_rising, cpuclk_falling, cpuclk_locked, cpuclk_lost, cpuclk_period,
    output c7m_sync, c7m_rising, c7m_falling
  );
  modport master (
    output cpuclk_in, c7m_in,
    input cpuclk_rising, cpuclk_falling, cpuclk_locked, cpuclk_lost, cpuclk_period,
    input c7m_sync, c7m_rising, c7m_falling
  );
`else
  modport slave (
    input cpuclk_in,
    output cpuclk_rising, cpuclk_falling, cpuclk_locked, cpuclk_lost, cpuclk_period
  );
  modport master (
    output cpuclk_in,
    input cpuclk_rising, cpuclk_falling, cpuclk_locked, cpuclk_lost, cpuclk_period
  );
`endif
endinterface

// File: rtl/edge_sync_filter.sv
// edge_sync_filter: synchronizes an async level, rejects short glitches and emits registered edge strobes
module edge_sync_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN = 2
) (
  input  logic clk100,
  input  logic reset_n_in,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);
  localparam int CW = $clog2(FILTER_LEN + 1);
  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0] filt_cnt;
  logic lvl_d, synced, flip;
  assign synced = sync[SYNC_STAGES-1];
  // the sample that completes FILTER_LEN disagreeing samples flips the level directly
  assign flip = (synced != lvl) && (filt_cnt == CW'(FILTER_LEN - 1));
  always_ff @(posedge clk100) begin
    if (!reset_n_in) begin
      sync <= '0;
      filt_cnt <= '0;
      lvl <= 1'b0;
      lvl_d <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
      filt_cnt <= (synced == lvl || flip) ? '0 : filt_cnt + 1'b1;
      lvl <= flip ? ~lvl : lvl;
      lvl_d <= lvl;
      rise <= lvl & ~lvl_d;
      fall <= ~lvl & lvl_d;
    end
  end
endmodule

// File: rtl/cpuclk_edge_gen.sv
// cpuclk_edge_gen: filtered CPU clock edge strobes gated by a period-measuring lock qualifier
// CPUCLK_EDGE_C7M_EN adds an ungated c7m_in edge path through the same filter.
module cpuclk_edge_gen
  import rebuster_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_D,
  parameter int FILTER_LEN = FILTER_LEN_D,
  parameter int PERIOD_W = PERIOD_W_D,
  parameter int LOCK_COUNT = LOCK_COUNT_D,
  parameter int PERIOD_TOL = PERIOD_TOL_D
) (
  input logic clk100,
  input logic reset_n_in,
  cpuclk_edge_gen_if.slave bus
);
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam logic [PERIOD_W-1:0] CMAX = '1;
  localparam logic [PERIOD_W-1:0] TOL = PERIOD_W'(PERIOD_TOL);
  lock_state_t state, state_nxt;
  logic rise, fall, cpu_lvl_unused, in_tol, timeout, locked, lost, lost_nxt;
  logic [PERIOD_W-1:0] cnt, meas, ref_p, ref_nxt, period, period_nxt;
  logic [MW-1:0] match, match_nxt;
  edge_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_cpu (
    .clk100(clk100), .reset_n_in(reset_n_in), .din(bus.cpuclk_in),
    .lvl(cpu_lvl_unused), .rise(rise), .fall(fall)
  );
  assign meas = (cnt == CMAX) ? CMAX : cnt + 1'b1;
  assign in_tol = (meas >= ref_p) ? (meas - ref_p <= TOL) : (ref_p - meas <= TOL);
  assign timeout = (cnt == CMAX) && !rise && (state != UNLOCKED);
  // lock follows the next state so the edge that breaks lock is already suppressed
  assign locked = state_nxt == LOCKED;
  always_comb begin
    state_nxt = state;
    ref_nxt = ref_p;
    match_nxt = match;
    period_nxt = period;
    lost_nxt = lost;
    if (timeout) begin
      state_nxt = UNLOCKED;
      period_nxt = '0;
      lost_nxt = lost | (state == LOCKED);
    end else if (rise) begin
      case (state)
        UNLOCKED: state_nxt = FIRST;
        FIRST: begin
          state_nxt = ACQUIRE;
          ref_nxt = meas;
          match_nxt = '0;
        end
        ACQUIRE: begin
          ref_nxt = in_tol ? ref_p : meas;
          match_nxt = in_tol ? match + 1'b1 : '0;
          if (in_tol && match == MW'(LOCK_COUNT - 1)) begin
            state_nxt = LOCKED;
            period_nxt = ref_p;
            lost_nxt = 1'b0;
          end
        end
        LOCKED: begin
          ref_nxt = meas;
          period_nxt = in_tol ? meas : '0;
          state_nxt = in_tol ? LOCKED : ACQUIRE;
          match_nxt = '0;
        end
        default: state_nxt = UNLOCKED;
      endcase
    end
  end
  always_ff @(posedge clk100) begin
    if (!reset_n_in) begin
      state <= UNLOCKED;
      cnt <= '0;
      ref_p <= '0;
      match <= '0;
      period <= '0;
      lost <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= rise ? '0 : meas;
      ref_p <= ref_nxt;
      match <= match_nxt;
      period <= period_nxt;
      lost <= lost_nxt;
    end
  end
  assign bus.cpuclk_rising = rise & locked;
  assign bus.cpuclk_falling = fall & locked;
  assign bus.cpuclk_locked = locked;
  assign bus.cpuclk_lost = lost;
  assign bus.cpuclk_period = period;
`ifdef CPUCLK_EDGE_C7M_EN
  edge_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_c7m (
    .clk100(clk100), .reset_n_in(reset_n_in), .din(bus.c7m_in),
    .lvl(bus.c7m_sync), .rise(bus.c7m_rising), .fall(bus.c7m_falling)
  );
`endif
endmodule

// File: tb/tb_cpuclk_edge_gen.sv
// tb_cpuclk_edge_gen: directed checks of lock acquisition, strobes, glitch rejection, timeout and reset
module tb_cpuclk_edge_gen;
  logic clk100 = 1'b0;
  logic reset_n_in = 1'b0;
  int passed = 0, total = 0;
  int cyc = 0, rise_n = 0, fall_n = 0, last_rise = 0, last_fall = 0, rise_gap = 0;
  int r0;
  cpuclk_edge_gen_if #(.PERIOD_W(6)) bus ();
  cpuclk_edge_gen dut (.clk100(clk100), .reset_n_in(reset_n_in), .bus(bus));
  always #5 clk100 = ~clk100;
  initial forever begin
    @(posedge clk100);
    #1;
    cyc++;
    if (bus.cpuclk_rising === 1'b1) begin
      rise_gap = cyc - last_rise;
      last_rise = cyc;
      rise_n++;
    end
    if (bus.cpuclk_falling === 1'b1) begin
      last_fall = cyc;
      fall_n++;
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: run still active at time limit, want $finish earlier");
    $fatal(1);
  end
  task automatic wave(input int hi, input int lo, input int n);
    repeat (n) begin
      bus.cpuclk_in = 1'b1;
      repeat (hi) @(negedge clk100);
      bus.cpuclk_in = 1'b0;
      repeat (lo) @(negedge clk100);
    end
  endtask
  task automatic test_reset;
    reset_n_in = 1'b0;
    bus.cpuclk_in = 1'b0;
`ifdef CPUCLK_EDGE_C7M_EN
    bus.c7m_in = 1'b0;
`endif
    repeat (3) @(negedge clk100);
    total++; if (bus.cpuclk_locked !== 1'b0) $display("FAIL reset_locked: got %b want 0", bus.cpuclk_locked); else passed++;
    total++; if (bus.cpuclk_lost !== 1'b0) $display("FAIL reset_lost: got %b want 0", bus.cpuclk_lost); else passed++;
    total++; if (bus.cpuclk_period !== 6'd0) $display("FAIL reset_period: got %0d want 0", bus.cpuclk_period); else passed++;
    total++; if (bus.cpuclk_rising !== 1'b0) $display("FAIL reset_rising: got %b want 0", bus.cpuclk_rising); else passed++;
    total++; if (bus.cpuclk_falling !== 1'b0) $display("FAIL reset_falling: got %b want 0", bus.cpuclk_falling); else passed++;
    reset_n_in = 1'b1;
  endtask
`ifdef CPUCLK_EDGE_C7M_EN
  task automatic test_c7m;
    bus.c7m_in = 1'b1;
    repeat (4) @(negedge clk100);
    total++; if (bus.c7m_rising !== 1'b0) $display("FAIL c7m_rise_early: got %b want 0", bus.c7m_rising); else passed++;
    @(negedge clk100);
    total++; if (bus.c7m_rising !== 1'b1) $display("FAIL c7m_rise_at_5: got %b want 1", bus.c7m_rising); else passed++;
    total++; if (bus.c7m_sync !== 1'b1) $display("FAIL c7m_sync_high: got %b want 1", bus.c7m_sync); else passed++;
    total++; if (bus.cpuclk_locked !== 1'b0) $display("FAIL c7m_unlocked: got %b want 0", bus.cpuclk_locked); else passed++;
    @(negedge clk100);
    total++; if (bus.c7m_rising !== 1'b0) $display("FAIL c7m_rise_single: got %b want 0", bus.c7m_rising); else passed++;
    @(negedge clk100);
    bus.c7m_in = 1'b0;
    repeat (4) @(negedge clk100);
    total++; if (bus.c7m_falling !== 1'b0) $display("FAIL c7m_fall_early: got %b want 0", bus.c7m_falling); else passed++;
    @(negedge clk100);
    total++; if (bus.c7m_falling !== 1'b1) $display("FAIL c7m_fall_at_5: got %b want 1", bus.c7m_falling); else passed++;
    repeat (3) @(negedge clk100);
  endtask
`endif
  task automatic test_lock;
    wave(2, 2, 9);
    total++; if (bus.cpuclk_locked !== 1'b0) $display("FAIL lock_early: got %b want 0", bus.cpuclk_locked); else passed++;
    total++; if (rise_n !== 0) $display("FAIL lock_no_rise_before: got %0d want 0", rise_n); else passed++;
    total++; if (fall_n !== 0) $display("FAIL lock_no_fall_before: got %0d want 0", fall_n); else passed++;
    wave(2, 2, 7);
    total++; if (bus.cpuclk_locked !== 1'b1) $display("FAIL lock_locked: got %b want 1", bus.cpuclk_locked); else passed++;
    total++; if (bus.cpuclk_period !== 6'd4) $display("FAIL lock_period: got %0d want 4", bus.cpuclk_period); else passed++;
    total++; if (rise_n !== 6) $display("FAIL lock_rise_count: got %0d want 6", rise_n); else passed++;
    total++; if (fall_n !== 6) $display("FAIL lock_fall_count: got %0d want 6", fall_n); else passed++;
    total++; if (rise_gap !== 4) $display("FAIL lock_rise_gap: got %0d want 4", rise_gap); else passed++;
    total++; if (last_fall - last_rise !== 2) $display("FAIL lock_fall_offset: got %0d want 2", last_fall - last_rise); else passed++;
  endtask
  task automatic test_tolerance;
    wave(3, 2, 4);
    total++; if (bus.cpuclk_locked !== 1'b1) $display("FAIL tol_locked: got %b want 1", bus.cpuclk_locked); else passed++;
    total++; if (bus.cpuclk_period !== 6'd5) $display("FAIL tol_period: got %0d want 5", bus.cpuclk_period); else passed++;
    total++; if (rise_gap !== 5) $display("FAIL tol_rise_gap: got %0d want 5", rise_gap); else passed++;
  endtask
  task automatic test_period_jump;
    r0 = rise_n;
    wave(4, 3, 2);
    total++; if (bus.cpuclk_locked !== 1'b0) $display("FAIL jump_unlocked: got %b want 0", bus.cpuclk_locked); else passed++;
    total++; if (bus.cpuclk_period !== 6'd0) $display("FAIL jump_period0: got %0d want 0", bus.cpuclk_period); else passed++;
    total++; if (rise_n - r0 !== 1) $display("FAIL jump_suppressed: got %0d strobes want 1", rise_n - r0); else passed++;
    wave(4, 3, 7);
    total++; if (bus.cpuclk_locked !== 1'b0) $display("FAIL jump_relock_early: got %b want 0", bus.cpuclk_locked); else passed++;
    wave(4, 3, 1);
    total++; if (bus.cpuclk_locked !== 1'b1) $display("FAIL jump_relocked: got %b want 1", bus.cpuclk_locked); else passed++;
    total++; if (bus.cpuclk_period !== 6'd7) $display("FAIL jump_period7: got %0d want 7", bus.cpuclk_period); else passed++;
  endtask
  task automatic test_glitch;
    r0 = rise_n;
    repeat (4) begin
      bus.cpuclk_in = 1'b1;
      repeat (2) @(negedge clk100);
      bus.cpuclk_in = 1'b0;
      @(negedge clk100);
      bus.cpuclk_in = 1'b1;
      repeat (2) @(negedge clk100);
      bus.cpuclk_in = 1'b0;
      repeat (2) @(negedge clk100);
    end
    total++; if (rise_n - r0 !== 4) $display("FAIL glitch_rise_count: got %0d want 4", rise_n - r0); else passed++;
    total++; if (bus.cpuclk_locked !== 1'b1) $display("FAIL glitch_locked: got %b want 1", bus.cpuclk_locked); else passed++;
    total++; if (bus.cpuclk_period !== 6'd7) $display("FAIL glitch_period: got %0d want 7", bus.cpuclk_period); else passed++;
  endtask
  task automatic test_timeout;
    r0 = rise_n;
    bus.cpuclk_in = 1'b0;
    repeat (80) @(negedge clk100);
    total++; if (bus.cpuclk_locked !== 1'b0) $display("FAIL timeout_locked: got %b want 0", bus.cpuclk_locked); else passed++;
    total++; if (bus.cpuclk_lost !== 1'b1) $display("FAIL timeout_lost: got %b want 1", bus.cpuclk_lost); else passed++;
    total++; if (bus.cpuclk_period !== 6'd0) $display("FAIL timeout_period: got %0d want 0", bus.cpuclk_period); else passed++;
    total++; if (rise_n - r0 !== 0) $display("FAIL timeout_no_rise: got %0d want 0", rise_n - r0); else passed++;
    wave(2, 2, 9);
    total++; if (bus.cpuclk_locked !== 1'b0) $display("FAIL restart_early: got %b want 0", bus.cpuclk_locked); else passed++;
    total++; if (bus.cpuclk_lost !== 1'b1) $display("FAIL restart_lost_sticky: got %b want 1", bus.cpuclk_lost); else passed++;
    wave(2, 2, 3);
    total++; if (bus.cpuclk_locked !== 1'b1) $display("FAIL restart_locked: got %b want 1", bus.cpuclk_locked); else passed++;
    total++; if (bus.cpuclk_lost !== 1'b0) $display("FAIL restart_lost_clear: got %b want 0", bus.cpuclk_lost); else passed++;
    total++; if (bus.cpuclk_period !== 6'd4) $display("FAIL restart_period: got %0d want 4", bus.cpuclk_period); else passed++;
  endtask
  task automatic test_reset_mid;
    reset_n_in = 1'b0;
    @(negedge clk100);
    reset_n_in = 1'b1;
    total++; if (bus.cpuclk_locked !== 1'b0) $display("FAIL midrst_locked: got %b want 0", bus.cpuclk_locked); else passed++;
    total++; if (bus.cpuclk_period !== 6'd0) $display("FAIL midrst_period: got %0d want 0", bus.cpuclk_period); else passed++;
    total++; if (bus.cpuclk_rising !== 1'b0) $display("FAIL midrst_rising: got %b want 0", bus.cpuclk_rising); else passed++;
    total++; if (bus.cpuclk_falling !== 1'b0) $display("FAIL midrst_falling: got %b want 0", bus.cpuclk_falling); else passed++;
    wave(2, 2, 9);
    total++; if (bus.cpuclk_locked !== 1'b0) $display("FAIL midrst_reacq_early: got %b want 0", bus.cpuclk_locked); else passed++;
    wave(2, 2, 3);
    total++; if (bus.cpuclk_locked !== 1'b1) $display("FAIL midrst_relocked: got %b want 1", bus.cpuclk_locked); else passed++;
    total++; if (bus.cpuclk_period !== 6'd4) $display("FAIL midrst_period4: got %0d want 4", bus.cpuclk_period); else passed++;
  endtask
  initial begin
    test_reset;
`ifdef CPUCLK_EDGE_C7M_EN
    test_c7m;
`endif
    test_lock;
    test_tolerance;
    test_period_jump;
    test_glitch;
    test_timeout;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
